bus_interconnect: RTL

Parametrised single-master, N-slave data-bus interconnect between the CPU data port and the memory-mapped peripherals (RAM, display, UART, status registers). Each slave claims an address window by base/mask. The block registers one transaction at a time and drives a one-hot slave request. It returns read data and ack to the master, and converts unmapped addresses and unresponsive slaves into error acks via a per-transaction timeout.

---
 rtl/bus_interconnect_if.sv | 30 +++
 rtl/bus_interconnect.sv | 99 +++++++++
 2 files changed

// File: rtl/bus_interconnect_if.sv
// bus_interconnect_if: CPU-side command/response and shared peripheral-side request/ack signals
interface bus_interconnect_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  logic [ADDR_W-1:0]            m_addr;
  logic [DATA_W-1:0]            m_wdata;
  logic                         m_wren;
  logic [DATA_W/8-1:0]          m_mask;
  logic                         m_req;
  logic                         m_ack;
  logic [DATA_W-1:0]            m_rdata;
  logic                         m_err;
  logic [NUM_SLAVES-1:0]        s_req;
  logic [ADDR_W-1:0]            s_addr;
  logic [DATA_W-1:0]            s_wdata;
  logic                         s_wren;
  logic [DATA_W/8-1:0]          s_mask;
  logic [NUM_SLAVES-1:0]        s_ack;
  logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
  modport master (
    input  m_addr, m_wdata, m_wren, m_mask, m_req, s_ack, s_rdata,
    output m_ack, m_rdata, m_err, s_req, s_addr, s_wdata, s_wren, s_mask
  );
  modport slave (
    output m_addr, m_wdata, m_wren, m_mask, m_req, s_ack, s_rdata,
    input  m_ack, m_rdata, m_err, s_req, s_addr, s_wdata, s_wren, s_mask
  );
endinterface

// File: rtl/bus_interconnect.sv
// bus_interconnect: single-master, N-slave decode with one-hot request, timeout and error counting
module bus_interconnect #(
  parameter int                          NUM_SLAVES = 4,
  parameter int                          ADDR_W     = 32,
  parameter int                          DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
  parameter int                          TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  bus_interconnect_if.master        bus,
  output logic [15:0]               err_count
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [IW-1:0]         sel, idx;
  logic                  hit, ld, ack_n, err_n;
  logic [DATA_W-1:0]     rdata_n;
  logic [NUM_SLAVES-1:0] req_n;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((bus.m_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = bus.s_req;
    ld      = 1'b0;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    rdata_n = '0;
    case (state)
      IDLE: if (bus.m_req) begin
        ld      = 1'b1;
        req_n   = hit ? NUM_SLAVES'(1) << idx : '0;
        cnt_n   = '0;
        ack_n   = !hit;
        err_n   = !hit;
        state_n = hit ? WAIT : HOLD;
      end
      WAIT: if (bus.s_ack[sel]) begin
        req_n   = '0;
        ack_n   = 1'b1;
        rdata_n = bus.s_wren ? '0 : bus.s_rdata[sel*DATA_W +: DATA_W];
        state_n = HOLD;
      end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
        req_n   = '0;
        ack_n   = 1'b1;
        err_n   = 1'b1;
        rdata_n = '1;
        state_n = HOLD;
      end else begin
        cnt_n = TIMEOUT == 0 ? cnt : cnt + CW'(1);
      end
      HOLD: state_n = bus.m_req ? HOLD : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sel         <= '0;
      bus.s_req   <= '0;
      bus.s_addr  <= '0;
      bus.s_wdata <= '0;
      bus.s_wren  <= 1'b0;
      bus.s_mask  <= '0;
      bus.m_ack   <= 1'b0;
      bus.m_err   <= 1'b0;
      bus.m_rdata <= '0;
      err_count   <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bus.s_req   <= req_n;
      bus.m_ack   <= ack_n;
      bus.m_err   <= err_n;
      bus.m_rdata <= rdata_n;
      if (ld) begin
        sel         <= idx;
        bus.s_addr  <= bus.m_addr;
        bus.s_wdata <= bus.m_wdata;
        bus.s_wren  <= bus.m_wren;
        bus.s_mask  <= bus.m_mask;
      end
      if (ack_n && err_n && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
endmodule
